// File: rtl/hpi_bus_sequencer_if.sv
// Avalon-MM slave bus bundle for hpi_bus_sequencer: request/address/data from the
// interconnect, readdata/waitrequest back to it.
interface hpi_bus_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/hpi_bus_sequencer.sv
// Hardware HPI cycle generator for the EZ-OTG controller: one Avalon access -> one
// timed HPI read/write. Optional sticky interrupt latch enabled by HPI_IRQ_LATCH_EN.
module hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  hpi_bus_sequencer_if.slave  avs,
  input  logic                otg_int,
  output logic                irq,
  input  logic [15:0]         otg_data_in,
  output logic [15:0]         otg_data_out,
  output logic                otg_data_oe,
  output logic [1:0]          otg_addr,
  output logic                otg_cs_n,
  output logic                otg_rd_n,
  output logic                otg_wr_n
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("hpi_bus_sequencer: SETUP_CYC must be 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("hpi_bus_sequencer: STROBE_CYC must be 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("hpi_bus_sequencer: HOLD_CYC must be 1..15");
  end
  if (RECOVER_CYC < 1 || RECOVER_CYC > 15) begin : g_bad_recover
    $error("hpi_bus_sequencer: RECOVER_CYC must be 1..15");
  end

  // Counters count down from (phase length - 1); a phase ends when the counter is 0.
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_q, oe_d;

  logic        request;
  logic        phase_last;
  logic        done;

  always_comb begin
    request    = avs.chipselect & (avs.read | avs.write);
    phase_last = (cnt_q == 4'd0);
    done       = (state_q == ST_RECOVER) && (cnt_q == RECOVER_LD);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          is_wr_d = avs.write;
          addr_d  = avs.address;
          if (avs.write) begin
            dout_d = avs.writedata;
          end
        end
      end
      ST_SETUP: begin
        if (phase_last) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (phase_last) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          if (!is_wr_q) begin
            rdata_d = otg_data_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (phase_last) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (phase_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin outputs are registered, so they are decoded from the state being entered.
    cs_n_d = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
    rd_n_d = !((state_d == ST_STROBE) && !is_wr_d);
    wr_n_d = !((state_d == ST_STROBE) && is_wr_d);
    oe_d   = is_wr_d && !cs_n_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
    end
  end

  assign avs.waitrequest = request & ~done;
  assign avs.readdata    = rdata_q;
  assign otg_data_out    = dout_q;
  assign otg_data_oe     = oe_q;
  assign otg_addr        = addr_q;
  assign otg_cs_n        = cs_n_q;
  assign otg_rd_n        = rd_n_q;
  assign otg_wr_n        = wr_n_q;

`ifdef HPI_IRQ_LATCH_EN
  logic sync1_q, sync2_q, sync3_q;
  logic irq_q, irq_d;

  // Set is applied after clear so a coincident edge keeps the interrupt pending.
  always_comb begin
    irq_d = irq_q;
    if (done && !is_wr_q && (addr_q == 2'd3)) begin
      irq_d = 1'b0;
    end
    if (sync2_q && !sync3_q) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= otg_int;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic otg_int_unused;
  assign otg_int_unused = otg_int;
  assign irq            = 1'b0;
`endif

endmodule
